// File: rtl/timer_tick_master.sv
// Avalon-MM master for a 16-bit interval timer: programs period/control, turns each
// serviced timeout into a tick pulse and snapshots the timer counter on request.
module timer_tick_master #(
  parameter bit CTRL_IRQ_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        snap_req,
  input  logic [31:0] period,
  input  logic        continuous,
  output logic [2:0]  av_address,
  output logic        av_chipselect,
  output logic        av_write_n,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  input  logic        timer_irq,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic [31:0] snap_value,
  output logic        snap_valid,
  output logic        busy,
  output logic        start_err
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR_ST, CLR_WAIT,
    WR_STOP, SNAP_TRIG, SNAP_RL, SNAP_RH, SNAP_CAP
  } state_t;

  state_t      state, state_n;
  logic [31:0] period_q;
  logic        cont_q;
  logic        stop_pend, snap_pend;
  logic        snap_ret_run;
  logic [15:0] snap_lo;
  logic        stop_go, snap_go;
  logic        period_ok, stop_eff, snap_eff;

  assign period_ok = (period >= 32'd2);
  // A request arriving in the servicing cycle counts as pending already.
  assign stop_eff  = stop_pend | stop;
  assign snap_eff  = snap_pend | snap_req;
  assign busy      = !((state == IDLE) || (state == RUN));

  always_comb begin
    state_n       = state;
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_address    = 3'd0;
    av_writedata  = 16'h0000;
    tick          = 1'b0;
    stop_go       = 1'b0;
    snap_go       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (period_ok) state_n = WR_PL;
        end else if (snap_eff) begin
          snap_go = 1'b1;
          state_n = SNAP_TRIG;
        end
      end
      WR_PL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd2;
        av_writedata  = period_q[15:0];
        state_n       = WR_PH;
      end
      WR_PH: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd3;
        av_writedata  = period_q[31:16];
        state_n       = WR_CTL;
      end
      WR_CTL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd1;
        av_writedata  = {12'b0, 1'b0, 1'b1, cont_q, CTRL_IRQ_EN};
        state_n       = RUN;
      end
      RUN: begin
        if (timer_irq) begin
          state_n = CLR_ST;
        end else if (stop_eff) begin
          stop_go = 1'b1;
          state_n = WR_STOP;
        end else if (snap_eff) begin
          snap_go = 1'b1;
          state_n = SNAP_TRIG;
        end
      end
      CLR_ST: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd0;
        tick          = 1'b1;
        state_n       = CLR_WAIT;
      end
      // The slave needs this cycle to drop irq after the status clear.
      CLR_WAIT: state_n = cont_q ? RUN : IDLE;
      WR_STOP: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd1;
        av_writedata  = 16'h0008;
        state_n       = IDLE;
      end
      SNAP_TRIG: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd4;
        state_n       = SNAP_RL;
      end
      SNAP_RL: begin
        av_chipselect = 1'b1;
        av_address    = 3'd4;
        state_n       = SNAP_RH;
      end
      SNAP_RH: begin
        av_chipselect = 1'b1;
        av_address    = 3'd5;
        state_n       = SNAP_CAP;
      end
      SNAP_CAP: state_n = snap_ret_run ? RUN : IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      period_q     <= 32'h0;
      cont_q       <= 1'b0;
      stop_pend    <= 1'b0;
      snap_pend    <= 1'b0;
      snap_ret_run <= 1'b0;
      snap_lo      <= 16'h0;
      snap_value   <= 32'h0;
      snap_valid   <= 1'b0;
      tick_count   <= 16'h0;
      start_err    <= 1'b0;
    end else begin
      state <= state_n;
      if ((state == IDLE) && start && period_ok) begin
        period_q <= period;
        cont_q   <= continuous;
      end
      if ((state == IDLE) || stop_go) stop_pend <= 1'b0;
      else if (stop)                  stop_pend <= 1'b1;
      if (snap_go || stop_go) snap_pend <= 1'b0;
      else if (snap_req)      snap_pend <= 1'b1;
      if (snap_go) snap_ret_run <= (state == RUN);
      // Read data lags the address by one cycle.
      if (state == SNAP_RH) snap_lo <= av_readdata;
      if (state == SNAP_CAP) snap_value <= {av_readdata, snap_lo};
      snap_valid <= (state == SNAP_CAP);
      if (state == CLR_ST) tick_count <= tick_count + 16'd1;
      start_err <= (state == IDLE) && start && !period_ok;
    end
  end

endmodule

// File: tb/tb_timer_tick_master.sv
// Randomized bench for timer_tick_master: a transaction-level model queues expected
// bus writes, ticks and snapshots; a negedge monitor consumes them as the DUT emits them.
module tb_timer_tick_master;
  logic        clk = 1'b0, reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, snap_req = 1'b0, continuous = 1'b0;
  logic [31:0] period = 32'h0;
  logic [2:0]  av_address;
  logic        av_chipselect, av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata = 16'h0;
  logic        timer_irq, tick, snap_valid, busy, start_err;
  logic [15:0] tick_count;
  logic [31:0] snap_value;

  timer_tick_master #(.CTRL_IRQ_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .snap_req(snap_req),
    .period(period), .continuous(continuous),
    .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
    .av_writedata(av_writedata), .av_readdata(av_readdata), .timer_irq(timer_irq),
    .tick(tick), .tick_count(tick_count), .snap_value(snap_value),
    .snap_valid(snap_valid), .busy(busy), .start_err(start_err)
  );

  always #5 clk = ~clk;

  // Timer slave: level irq cleared by a status write, snapshot latched by a write to 4.
  logic        irq_q = 1'b0, irq_fire = 1'b0, irq_clr = 1'b0;
  logic [31:0] snap_src = 32'h0, slv_snap = 32'h0;
  assign timer_irq = irq_q;
  always @(posedge clk) begin
    if (irq_clr || (av_chipselect && !av_write_n && av_address == 3'd0)) irq_q <= 1'b0;
    else if (irq_fire) irq_q <= 1'b1;
    if (av_chipselect && !av_write_n && av_address == 3'd4) slv_snap <= snap_src;
    if (av_chipselect && av_write_n)
      av_readdata <= (av_address == 3'd4) ? slv_snap[15:0] :
                     (av_address == 3'd5) ? slv_snap[31:16] : 16'h0;
    else
      av_readdata <= 16'h0;
  end

  // Expected traffic, written only by the stimulus process.
  logic [18:0] wq[$];
  logic [15:0] tq[$];
  logic [31:0] sq[$];
  int          err_exp = 0, timeouts = 0, m_ticks = 0;
  bit          fin_req = 1'b0;
  bit          m_run = 1'b0, m_cont = 1'b0;
  logic [15:0] m_cnt = 16'h0;

  int          assert_cnt = 0, fail_cnt = 0;
  int          rd_w = 0, rd_t = 0, rd_s = 0, err_seen = 0, tick_seen = 0;
  int          cyc_n = 0, trig_cyc = 0, last_wr = -10;
  bit          tick_chk = 1'b0, fin_done = 1'b0;
  logic [15:0] tick_exp = 16'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    assert_cnt++;
    fail_cnt++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("rst_bus", 64'({av_chipselect, av_write_n, av_address, av_writedata}),
            64'({1'b0, 1'b1, 3'd0, 16'd0}));
      check("rst_tick_count", 64'(tick_count), 64'(0));
      check("rst_snap_value", 64'(snap_value), 64'(0));
      check("rst_pulses", 64'({tick, snap_valid, busy, start_err}), 64'(0));
    end else begin
      cyc_n++;
      if (av_chipselect && !av_write_n) begin
        if (rd_w < wq.size()) begin
          check("bus_write", 64'({av_address, av_writedata}), 64'(wq[rd_w]));
          rd_w++;
        end else unexpected("bus_write", 64'({av_address, av_writedata}));
        if (av_address == 3'd3 || (av_address == 3'd1 && av_writedata[2]))
          check("wr_back_to_back", 64'(cyc_n - last_wr), 64'(1));
        if (av_address == 3'd4) trig_cyc = cyc_n;
        last_wr = cyc_n;
      end else if (!av_chipselect) begin
        check("bus_idle_write_n", 64'(av_write_n), 64'(1));
      end
      if (tick_chk) begin
        check("tick_count", 64'(tick_count), 64'(tick_exp));
        tick_chk = 1'b0;
      end
      if (tick) begin
        tick_seen++;
        if (rd_t < tq.size()) begin
          tick_exp = tq[rd_t];
          rd_t++;
          tick_chk = 1'b1;
        end else unexpected("tick", 64'(tick_count));
      end
      if (snap_valid) begin
        if (rd_s < sq.size()) begin
          check("snap_value", 64'(snap_value), 64'(sq[rd_s]));
          check("snap_latency", 64'(cyc_n - trig_cyc), 64'(4));
          rd_s++;
        end else unexpected("snap_valid", 64'(snap_value));
      end
      if (start_err) begin
        check("start_err_expected", 64'(err_seen < err_exp), 64'(1));
        err_seen++;
      end
      if (fin_req && !fin_done) begin
        check("writes_all_seen", 64'(rd_w), 64'(wq.size()));
        check("ticks_all_seen", 64'(rd_t), 64'(tq.size()));
        check("tick_total", 64'(tick_seen), 64'(m_ticks));
        check("snaps_all_seen", 64'(rd_s), 64'(sq.size()));
        check("start_err_total", 64'(err_seen), 64'(err_exp));
        check("timeouts", 64'(timeouts), 64'(0));
        fin_done = 1'b1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet();
    int q = 0;
    int b = 300;
    while (q < 3 && b > 0) begin
      cyc(1);
      if (busy) q = 0;
      else q++;
      b--;
    end
    if (q < 3) timeouts++;
  endtask

  task automatic op_start(input logic [31:0] p, input bit c);
    if (!m_run) begin
      if (p >= 32'd2) begin
        wq.push_back({3'd2, p[15:0]});
        wq.push_back({3'd3, p[31:16]});
        wq.push_back({3'd1, 12'b0, 1'b0, 1'b1, c, 1'b1});
        m_run  = 1'b1;
        m_cont = c;
      end else err_exp++;
    end
    period = p; continuous = c; start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_quiet();
  endtask

  task automatic model_tick();
    wq.push_back({3'd0, 16'h0});
    m_cnt = m_cnt + 16'd1;
    tq.push_back(m_cnt);
    m_ticks++;
  endtask

  task automatic op_irq();
    model_tick();
    if (!m_cont) m_run = 1'b0;
    irq_fire = 1'b1;
    cyc(1);
    irq_fire = 1'b0;
    wait_quiet();
  endtask

  task automatic op_snap(input logic [31:0] v);
    snap_src = v;
    wq.push_back({3'd4, 16'h0});
    sq.push_back(v);
    snap_req = 1'b1;
    cyc(1);
    snap_req = 1'b0;
    wait_quiet();
  endtask

  task automatic op_stop();
    if (m_run) begin
      wq.push_back({3'd1, 16'h0008});
      m_run = 1'b0;
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    wait_quiet();
  endtask

  initial begin
    logic [31:0] p;
    cyc(4);
    reset = 1'b0;
    cyc(2);

    op_start(32'h0001_86A0, 1'b1);
    repeat (3) op_irq();
    op_snap(32'h0000_1234);
    op_start(32'h0000_0100, 1'b0);   // ignored while running

    // irq, stop and snap all seen in one RUN cycle
    snap_src = $urandom;
    irq_fire = 1'b1;
    cyc(1);
    irq_fire = 1'b0;
    stop = 1'b1; snap_req = 1'b1;
    cyc(1);
    stop = 1'b0; snap_req = 1'b0;
    model_tick();
    wq.push_back({3'd1, 16'h0008});
    m_run = 1'b0;
    wait_quiet();

    op_stop();                        // discarded in IDLE
    op_start(32'h1, 1'b1);
    op_start(32'h0, 1'b0);
    op_snap($urandom);                // launched from IDLE, must return there

    op_start($urandom | 32'h10, 1'b0);
    op_irq();
    irq_fire = 1'b1;                  // no tick expected once back in IDLE
    cyc(1);
    irq_fire = 1'b0;
    cyc(10);
    irq_clr = 1'b1;
    cyc(1);
    irq_clr = 1'b0;
    cyc(1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          p = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
          op_start(p, 1'($urandom_range(0, 1)));
        end
        1: if (m_run) op_irq(); else op_snap($urandom);
        2: op_snap($urandom);
        default: op_stop();
      endcase
    end

    // reset in the middle of the programming sequence
    if (m_run) op_stop();
    p = $urandom | 32'h10;
    wq.push_back({3'd2, p[15:0]});
    period = p; continuous = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    m_run = 1'b0;
    m_cnt = 16'h0;
    cyc(2);
    op_start(32'h0000_0020, 1'b1);
    op_irq();
    op_stop();

    cyc(2);
    fin_req = 1'b1;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/timer_tick_master.md
TIMER_TICK_MASTER -- requirements
Module: timer_tick_master

Interface
REQ-001 SHALL have parameter CTRL_IRQ_EN, default 1: drives the interrupt-enable bit (bit 0) in every start control word.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to program and start the timer.
REQ-005 SHALL have port stop  input  1  one-cycle request to stop the timer.
REQ-006 SHALL have port snap_req  input  1  one-cycle request to capture the timer's counter.
REQ-007 SHALL have port period  input  32  load value; sampled when start is accepted.
REQ-008 SHALL have port continuous  input  1  1 = periodic, 0 = one-shot; sampled with period.
REQ-009 SHALL have ports av_address output 3, av_chipselect output 1, av_write_n output 1, av_writedata output 16, av_readdata input 16; this is an Avalon-MM master to the 16-bit timer slave (no waitrequest, readdata registered, one-cycle read latency).
REQ-010 SHALL have port timer_irq  input  1  timer interrupt, level.
REQ-011 SHALL have ports tick output 1 (one-cycle pulse per serviced timeout), tick_count output 16, snap_value output 32, snap_valid output 1 (one-cycle pulse), busy output 1, start_err output 1 (one-cycle pulse).

Function
REQ-012 SHALL implement states IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR_ST, CLR_WAIT, WR_STOP, SNAP_TRIG, SNAP_RL, SNAP_RH, SNAP_CAP; every write state occupies exactly one cycle.
REQ-013 SHALL drive av_chipselect=1 and av_write_n=0 only in WR_PL, WR_PH, WR_CTL, CLR_ST, WR_STOP and SNAP_TRIG; av_chipselect=1 and av_write_n=1 in SNAP_RL and SNAP_RH; av_chipselect=0, av_write_n=1 elsewhere.
REQ-014 SHALL, in IDLE with start=1 and period>=2, latch period and continuous, then sequence WR_PL (addr 2, period[15:0]), WR_PH (addr 3, period[31:16]), WR_CTL (addr 1, data {12'b0, 0, 1, continuous, CTRL_IRQ_EN}), then RUN.
REQ-015 SHALL, in IDLE with start=1 and period<2, remain in IDLE and pulse start_err for one cycle.
REQ-016 SHALL ignore start in any state other than IDLE, with no start_err.
REQ-017 SHALL, in RUN, service in priority order timer_irq, then pending stop, then pending snap.
REQ-018 SHALL, on timer_irq=1 in RUN, go to CLR_ST (addr 0, data 0), then pulse tick and increment tick_count in the CLR_ST cycle, then spend one cycle in CLR_WAIT (timer_irq ignored while the slave deasserts irq).
REQ-019 SHALL, from CLR_WAIT, return to RUN if the latched continuous=1, otherwise go to IDLE.
REQ-020 SHALL, on a stop serviced in RUN, go to WR_STOP (addr 1, data 16'h0008), then IDLE.
REQ-021 SHALL, on a snap serviced in RUN or on snap_req in IDLE, sequence SNAP_TRIG (addr 4, data 0), then SNAP_RL (addr 4), then SNAP_RH (addr 5, capture av_readdata as low half), then SNAP_CAP (capture av_readdata as high half, pulse snap_valid, update snap_value).
REQ-022 SHALL return from SNAP_CAP to the state the snapshot was launched from (RUN or IDLE).
REQ-023 SHALL latch stop and snap_req arriving in any state into pending flags and clear each flag when serviced; a stop in IDLE SHALL be discarded.
REQ-024 SHALL, when a pending stop is serviced, also clear any pending snap.
REQ-025 SHALL wrap tick_count from 16'hFFFF to 0 without flagging.
REQ-026 SHALL drive busy=1 in every state except IDLE and RUN.
REQ-027 SHALL drive snap_value unchanged between captures.

Reset
REQ-028 SHALL, while reset=1, force state IDLE, av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0, tick=0, tick_count=0, snap_value=0, snap_valid=0, busy=0, start_err=0 and clear all pending flags.
REQ-029 SHALL, on reset asserted mid-sequence, abandon the sequence with no further bus cycles; the timer slave is not assumed reset.

Verification
REQ-030 Bench: start with period=32'h0001_86A0, continuous=1 -> writes addr2=16'h86A0, addr3=16'h0001, addr1=16'h0007 on three consecutive cycles; RUN entered.
REQ-031 Bench: in RUN, assert timer_irq for 3 periods -> three addr0 writes of 0, three tick pulses, tick_count=3, state RUN after each.
REQ-032 Bench: continuous=0, one irq -> one tick, CLR_ST, CLR_WAIT, IDLE; a later irq produces no tick.
REQ-033 Bench: snap_req in RUN, slave model returns 16'h1234 then 16'h0000 -> snap_value=32'h0000_1234, snap_valid 4 cycles after the request is serviced, back in RUN.
REQ-034 Bench: timer_irq, stop and snap_req in the same RUN cycle -> irq serviced first, then WR_STOP writes addr1=16'h0008, snap discarded, IDLE; start with period=1 -> start_err, no bus write.
REQ-035 Bench: reset during WR_PH -> av_chipselect=0 immediately, tick_count=0, IDLE after release.
